// File: rtl/core_axi_pkg.sv
// rtl/core_axi_pkg.sv - shared encodings for the core AXI4-Lite arbiter
//
// Purpose: FSM state encodings, GRANT owner codes and AXI RESP constants
// shared by core_axi_arbiter and core_arb_pick.
// Ports: none (package).

package core_axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_RD_ADDR      = 3'd1,
    ST_RD_DATA      = 3'd2,
    ST_WR_ADDR_DATA = 3'd3,
    ST_WR_RESP      = 3'd4
  } arb_state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_IMEM = 2'b01;
  localparam logic [1:0] GRANT_DMEM = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/core_arb_pick.sv
// rtl/core_arb_pick.sv - two-way winner select between IMEM and DMEM requests
//
// Purpose: combinational choice of the next bus owner from the requests seen
// in IDLE. DMEM write always precedes DMEM read. Between the two masters the
// default is fixed priority (DMEM over IMEM); with CORE_AXI_ARB_RR_EN defined
// a last_grant register alternates the winner on contention.
// Ports:
//   clk, rst     clock / sync active-high reset (CORE_AXI_ARB_RR_EN only)
//   take         a grant is being registered this cycle (CORE_AXI_ARB_RR_EN only)
//   imem_req     IMEM read request
//   dmem_rd_req  DMEM read request
//   dmem_wr_req  DMEM write request (AWVALID | WVALID)
//   win_grant    winner code (NONE/IMEM/DMEM)
//   win_write    winner is a DMEM write

import core_axi_pkg::*;

module core_arb_pick (
`ifdef CORE_AXI_ARB_RR_EN
  input  logic       clk,
  input  logic       rst,
  input  logic       take,
`endif
  input  logic       imem_req,
  input  logic       dmem_rd_req,
  input  logic       dmem_wr_req,
  output logic [1:0] win_grant,
  output logic       win_write
);

  logic dmem_req;
  logic dmem_wins;

  assign dmem_req = dmem_rd_req | dmem_wr_req;

`ifdef CORE_AXI_ARB_RR_EN
  logic [1:0] last_grant;

  // Resetting to DMEM makes IMEM the winner of the first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= GRANT_DMEM;
    end else if (take) begin
      last_grant <= win_grant;
    end
  end

  assign dmem_wins = dmem_req & (~imem_req | (last_grant == GRANT_IMEM));
`else
  assign dmem_wins = dmem_req;
`endif

  always_comb begin
    win_grant = GRANT_NONE;
    if (dmem_wins) begin
      win_grant = GRANT_DMEM;
    end else if (imem_req) begin
      win_grant = GRANT_IMEM;
    end
  end

  assign win_write = dmem_wins & dmem_wr_req;

endmodule

// File: rtl/core_axi_arbiter.sv
// rtl/core_axi_arbiter.sv - two-to-one AXI4-Lite arbiter, IMEM/DMEM onto one slave port
//
// Purpose: shares MEM_AXI_* between the read-only IMEM master and the
// read/write DMEM master. One transaction in flight; the owner is chosen in
// IDLE and held until its response handshake. All channel paths are
// combinational pass-through, gated by state so idle outputs are 0.
// Optional: CORE_AXI_ARB_RR_EN selects round-robin between the masters.
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   IMEM_AXI_AR*/R*     IMEM read address / read data (slave side)
//   DMEM_AXI_AW*/W*/B*  DMEM write address / write data / write response
//   DMEM_AXI_AR*/R*     DMEM read address / read data
//   MEM_AXI_*           downstream master port, all five channels
//   GRANT               current owner: 00 none, 01 IMEM, 10 DMEM

import core_axi_pkg::*;

module core_axi_arbiter #(
  parameter int AXI_AWIDTH = 32,
  parameter int AXI_DWIDTH = 32
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [AXI_AWIDTH-1:0]   IMEM_AXI_ARADDR,
  input  logic                    IMEM_AXI_ARVALID,
  output logic                    IMEM_AXI_ARREADY,
  output logic [AXI_DWIDTH-1:0]   IMEM_AXI_RDATA,
  output logic [1:0]              IMEM_AXI_RRESP,
  output logic                    IMEM_AXI_RVALID,
  input  logic                    IMEM_AXI_RREADY,
  input  logic [AXI_AWIDTH-1:0]   DMEM_AXI_AWADDR,
  input  logic                    DMEM_AXI_AWVALID,
  output logic                    DMEM_AXI_AWREADY,
  input  logic [AXI_DWIDTH-1:0]   DMEM_AXI_WDATA,
  input  logic [AXI_DWIDTH/8-1:0] DMEM_AXI_WSTRB,
  input  logic                    DMEM_AXI_WVALID,
  output logic                    DMEM_AXI_WREADY,
  output logic [1:0]              DMEM_AXI_BRESP,
  output logic                    DMEM_AXI_BVALID,
  input  logic                    DMEM_AXI_BREADY,
  input  logic [AXI_AWIDTH-1:0]   DMEM_AXI_ARADDR,
  input  logic                    DMEM_AXI_ARVALID,
  output logic                    DMEM_AXI_ARREADY,
  output logic [AXI_DWIDTH-1:0]   DMEM_AXI_RDATA,
  output logic [1:0]              DMEM_AXI_RRESP,
  output logic                    DMEM_AXI_RVALID,
  input  logic                    DMEM_AXI_RREADY,
  output logic [AXI_AWIDTH-1:0]   MEM_AXI_AWADDR,
  output logic                    MEM_AXI_AWVALID,
  input  logic                    MEM_AXI_AWREADY,
  output logic [AXI_DWIDTH-1:0]   MEM_AXI_WDATA,
  output logic [AXI_DWIDTH/8-1:0] MEM_AXI_WSTRB,
  output logic                    MEM_AXI_WVALID,
  input  logic                    MEM_AXI_WREADY,
  input  logic [1:0]              MEM_AXI_BRESP,
  input  logic                    MEM_AXI_BVALID,
  output logic                    MEM_AXI_BREADY,
  output logic [AXI_AWIDTH-1:0]   MEM_AXI_ARADDR,
  output logic                    MEM_AXI_ARVALID,
  input  logic                    MEM_AXI_ARREADY,
  input  logic [AXI_DWIDTH-1:0]   MEM_AXI_RDATA,
  input  logic [1:0]              MEM_AXI_RRESP,
  input  logic                    MEM_AXI_RVALID,
  output logic                    MEM_AXI_RREADY,
  output logic [1:0]              GRANT
);

  arb_state_t state;
  logic [1:0] grant;
  logic       aw_done;
  logic       w_done;
  logic [1:0] win_grant;
  logic       win_write;

  logic st_rd_addr, st_rd_data, st_wr_ad, st_wr_resp;
  logic g_imem, g_dmem;
  logic ar_fire, r_fire, aw_fire, w_fire, b_fire;

  assign st_rd_addr = (state == ST_RD_ADDR);
  assign st_rd_data = (state == ST_RD_DATA);
  assign st_wr_ad   = (state == ST_WR_ADDR_DATA);
  assign st_wr_resp = (state == ST_WR_RESP);
  assign g_imem     = (grant == GRANT_IMEM);
  assign g_dmem     = (grant == GRANT_DMEM);

`ifdef CORE_AXI_ARB_RR_EN
  logic take;
  assign take = (state == ST_IDLE) && (win_grant != GRANT_NONE);
`endif

  core_arb_pick u_pick (
`ifdef CORE_AXI_ARB_RR_EN
    .clk         (CLK),
    .rst         (RST),
    .take        (take),
`endif
    .imem_req    (IMEM_AXI_ARVALID),
    .dmem_rd_req (DMEM_AXI_ARVALID),
    .dmem_wr_req (DMEM_AXI_AWVALID | DMEM_AXI_WVALID),
    .win_grant   (win_grant),
    .win_write   (win_write)
  );

  // Read address: only the owner's AR reaches the slave and sees ARREADY.
  assign MEM_AXI_ARVALID  = st_rd_addr & (g_dmem ? DMEM_AXI_ARVALID : IMEM_AXI_ARVALID);
  assign MEM_AXI_ARADDR   = st_rd_addr ? (g_dmem ? DMEM_AXI_ARADDR : IMEM_AXI_ARADDR) : '0;
  assign IMEM_AXI_ARREADY = st_rd_addr & g_imem & MEM_AXI_ARREADY;
  assign DMEM_AXI_ARREADY = st_rd_addr & g_dmem & MEM_AXI_ARREADY;

  // Read data: routed back to the owner only.
  assign MEM_AXI_RREADY  = st_rd_data & (g_dmem ? DMEM_AXI_RREADY : IMEM_AXI_RREADY);
  assign IMEM_AXI_RVALID = st_rd_data & g_imem & MEM_AXI_RVALID;
  assign DMEM_AXI_RVALID = st_rd_data & g_dmem & MEM_AXI_RVALID;
  assign IMEM_AXI_RDATA  = (st_rd_data & g_imem) ? MEM_AXI_RDATA : '0;
  assign IMEM_AXI_RRESP  = (st_rd_data & g_imem) ? MEM_AXI_RRESP : '0;
  assign DMEM_AXI_RDATA  = (st_rd_data & g_dmem) ? MEM_AXI_RDATA : '0;
  assign DMEM_AXI_RRESP  = (st_rd_data & g_dmem) ? MEM_AXI_RRESP : '0;

  // Write address/data run independently; a finished channel is masked so
  // the slave never sees a second handshake on it.
  assign MEM_AXI_AWVALID  = st_wr_ad & ~aw_done & DMEM_AXI_AWVALID;
  assign MEM_AXI_AWADDR   = st_wr_ad ? DMEM_AXI_AWADDR : '0;
  assign DMEM_AXI_AWREADY = st_wr_ad & ~aw_done & MEM_AXI_AWREADY;
  assign MEM_AXI_WVALID   = st_wr_ad & ~w_done & DMEM_AXI_WVALID;
  assign MEM_AXI_WDATA    = st_wr_ad ? DMEM_AXI_WDATA : '0;
  assign MEM_AXI_WSTRB    = st_wr_ad ? DMEM_AXI_WSTRB : '0;
  assign DMEM_AXI_WREADY  = st_wr_ad & ~w_done & MEM_AXI_WREADY;

  assign MEM_AXI_BREADY  = st_wr_resp & DMEM_AXI_BREADY;
  assign DMEM_AXI_BVALID = st_wr_resp & MEM_AXI_BVALID;
  assign DMEM_AXI_BRESP  = st_wr_resp ? MEM_AXI_BRESP : '0;

  assign ar_fire = MEM_AXI_ARVALID & MEM_AXI_ARREADY;
  assign r_fire  = MEM_AXI_RVALID  & MEM_AXI_RREADY;
  assign aw_fire = MEM_AXI_AWVALID & MEM_AXI_AWREADY;
  assign w_fire  = MEM_AXI_WVALID  & MEM_AXI_WREADY;
  assign b_fire  = MEM_AXI_BVALID  & MEM_AXI_BREADY;

  assign GRANT = grant;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= ST_IDLE;
      grant   <= GRANT_NONE;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (win_grant != GRANT_NONE) begin
            grant <= win_grant;
            state <= win_write ? ST_WR_ADDR_DATA : ST_RD_ADDR;
          end
        end
        ST_RD_ADDR: begin
          if (ar_fire) state <= ST_RD_DATA;
        end
        ST_RD_DATA: begin
          if (r_fire) begin
            state <= ST_IDLE;
            grant <= GRANT_NONE;
          end
        end
        ST_WR_ADDR_DATA: begin
          if (aw_fire) aw_done <= 1'b1;
          if (w_fire)  w_done  <= 1'b1;
          // Covers both handshakes landing in the same cycle.
          if ((aw_done | aw_fire) & (w_done | w_fire)) begin
            state   <= ST_WR_RESP;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end
        end
        ST_WR_RESP: begin
          if (b_fire) begin
            state <= ST_IDLE;
            grant <= GRANT_NONE;
          end
        end
        default: begin
          state <= ST_IDLE;
          grant <= GRANT_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_axi_arbiter.sv
// tb/tb_core_axi_arbiter.sv - directed self-checking bench for core_axi_arbiter

module tb_core_axi_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] IMEM_AXI_ARADDR;
  logic        IMEM_AXI_ARVALID;
  logic        IMEM_AXI_ARREADY;
  logic [31:0] IMEM_AXI_RDATA;
  logic [1:0]  IMEM_AXI_RRESP;
  logic        IMEM_AXI_RVALID;
  logic        IMEM_AXI_RREADY;
  logic [31:0] DMEM_AXI_AWADDR;
  logic        DMEM_AXI_AWVALID;
  logic        DMEM_AXI_AWREADY;
  logic [31:0] DMEM_AXI_WDATA;
  logic [3:0]  DMEM_AXI_WSTRB;
  logic        DMEM_AXI_WVALID;
  logic        DMEM_AXI_WREADY;
  logic [1:0]  DMEM_AXI_BRESP;
  logic        DMEM_AXI_BVALID;
  logic        DMEM_AXI_BREADY;
  logic [31:0] DMEM_AXI_ARADDR;
  logic        DMEM_AXI_ARVALID;
  logic        DMEM_AXI_ARREADY;
  logic [31:0] DMEM_AXI_RDATA;
  logic [1:0]  DMEM_AXI_RRESP;
  logic        DMEM_AXI_RVALID;
  logic        DMEM_AXI_RREADY;
  logic [31:0] MEM_AXI_AWADDR;
  logic        MEM_AXI_AWVALID;
  logic        MEM_AXI_AWREADY;
  logic [31:0] MEM_AXI_WDATA;
  logic [3:0]  MEM_AXI_WSTRB;
  logic        MEM_AXI_WVALID;
  logic        MEM_AXI_WREADY;
  logic [1:0]  MEM_AXI_BRESP;
  logic        MEM_AXI_BVALID;
  logic        MEM_AXI_BREADY;
  logic [31:0] MEM_AXI_ARADDR;
  logic        MEM_AXI_ARVALID;
  logic        MEM_AXI_ARREADY;
  logic [31:0] MEM_AXI_RDATA;
  logic [1:0]  MEM_AXI_RRESP;
  logic        MEM_AXI_RVALID;
  logic        MEM_AXI_RREADY;
  logic [1:0]  GRANT;

  int n_checks;
  int n_errors;
  int aw_hs, w_hs, b_hs;
  logic [1:0] first_win;
  logic [1:0] post_rst_win;

  always #5 CLK = ~CLK;

  core_axi_arbiter #(.AXI_AWIDTH(32), .AXI_DWIDTH(32)) dut (
    .CLK(CLK), .RST(RST),
    .IMEM_AXI_ARADDR(IMEM_AXI_ARADDR), .IMEM_AXI_ARVALID(IMEM_AXI_ARVALID),
    .IMEM_AXI_ARREADY(IMEM_AXI_ARREADY), .IMEM_AXI_RDATA(IMEM_AXI_RDATA),
    .IMEM_AXI_RRESP(IMEM_AXI_RRESP), .IMEM_AXI_RVALID(IMEM_AXI_RVALID),
    .IMEM_AXI_RREADY(IMEM_AXI_RREADY),
    .DMEM_AXI_AWADDR(DMEM_AXI_AWADDR), .DMEM_AXI_AWVALID(DMEM_AXI_AWVALID),
    .DMEM_AXI_AWREADY(DMEM_AXI_AWREADY), .DMEM_AXI_WDATA(DMEM_AXI_WDATA),
    .DMEM_AXI_WSTRB(DMEM_AXI_WSTRB), .DMEM_AXI_WVALID(DMEM_AXI_WVALID),
    .DMEM_AXI_WREADY(DMEM_AXI_WREADY), .DMEM_AXI_BRESP(DMEM_AXI_BRESP),
    .DMEM_AXI_BVALID(DMEM_AXI_BVALID), .DMEM_AXI_BREADY(DMEM_AXI_BREADY),
    .DMEM_AXI_ARADDR(DMEM_AXI_ARADDR), .DMEM_AXI_ARVALID(DMEM_AXI_ARVALID),
    .DMEM_AXI_ARREADY(DMEM_AXI_ARREADY), .DMEM_AXI_RDATA(DMEM_AXI_RDATA),
    .DMEM_AXI_RRESP(DMEM_AXI_RRESP), .DMEM_AXI_RVALID(DMEM_AXI_RVALID),
    .DMEM_AXI_RREADY(DMEM_AXI_RREADY),
    .MEM_AXI_AWADDR(MEM_AXI_AWADDR), .MEM_AXI_AWVALID(MEM_AXI_AWVALID),
    .MEM_AXI_AWREADY(MEM_AXI_AWREADY), .MEM_AXI_WDATA(MEM_AXI_WDATA),
    .MEM_AXI_WSTRB(MEM_AXI_WSTRB), .MEM_AXI_WVALID(MEM_AXI_WVALID),
    .MEM_AXI_WREADY(MEM_AXI_WREADY), .MEM_AXI_BRESP(MEM_AXI_BRESP),
    .MEM_AXI_BVALID(MEM_AXI_BVALID), .MEM_AXI_BREADY(MEM_AXI_BREADY),
    .MEM_AXI_ARADDR(MEM_AXI_ARADDR), .MEM_AXI_ARVALID(MEM_AXI_ARVALID),
    .MEM_AXI_ARREADY(MEM_AXI_ARREADY), .MEM_AXI_RDATA(MEM_AXI_RDATA),
    .MEM_AXI_RRESP(MEM_AXI_RRESP), .MEM_AXI_RVALID(MEM_AXI_RVALID),
    .MEM_AXI_RREADY(MEM_AXI_RREADY),
    .GRANT(GRANT)
  );

  // Downstream write-side handshake counters, sampled mid-cycle.
  always @(negedge CLK) begin
    if (!RST) begin
      if (MEM_AXI_AWVALID && MEM_AXI_AWREADY) aw_hs++;
      if (MEM_AXI_WVALID && MEM_AXI_WREADY)   w_hs++;
      if (MEM_AXI_BVALID && MEM_AXI_BREADY)   b_hs++;
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs;
    IMEM_AXI_ARADDR = '0; IMEM_AXI_ARVALID = 0; IMEM_AXI_RREADY = 0;
    DMEM_AXI_AWADDR = '0; DMEM_AXI_AWVALID = 0; DMEM_AXI_WDATA = '0;
    DMEM_AXI_WSTRB = '0;  DMEM_AXI_WVALID = 0;  DMEM_AXI_BREADY = 0;
    DMEM_AXI_ARADDR = '0; DMEM_AXI_ARVALID = 0; DMEM_AXI_RREADY = 0;
    MEM_AXI_AWREADY = 0;  MEM_AXI_WREADY = 0;   MEM_AXI_BRESP = '0;
    MEM_AXI_BVALID = 0;   MEM_AXI_ARREADY = 0;  MEM_AXI_RDATA = '0;
    MEM_AXI_RRESP = '0;   MEM_AXI_RVALID = 0;
  endtask

  // Every upstream/downstream control and data output must be 0.
  task automatic check_quiet(input string tag);
    check_val({tag, "_ctl"}, {GRANT, IMEM_AXI_ARREADY, IMEM_AXI_RVALID, DMEM_AXI_AWREADY,
              DMEM_AXI_WREADY, DMEM_AXI_BVALID, DMEM_AXI_ARREADY, DMEM_AXI_RVALID,
              MEM_AXI_AWVALID, MEM_AXI_WVALID, MEM_AXI_BREADY, MEM_AXI_ARVALID,
              MEM_AXI_RREADY}, 64'd0);
    check_val({tag, "_rdat"}, {IMEM_AXI_RDATA, DMEM_AXI_RDATA}, 64'd0);
    check_val({tag, "_addr"}, {MEM_AXI_ARADDR, MEM_AXI_AWADDR}, 64'd0);
    check_val({tag, "_wdat"}, {MEM_AXI_WDATA, MEM_AXI_WSTRB, IMEM_AXI_RRESP,
              DMEM_AXI_RRESP, DMEM_AXI_BRESP}, 64'd0);
  endtask

  // Zero-wait read. Caller raises the ARVALID(s) in an IDLE cycle and
  // lowers them afterwards; returns in the IDLE cycle after the R handshake.
  task automatic do_read(input string tag, input logic [1:0] g, input logic [31:0] addr,
                         input logic [31:0] data, input logic [1:0] resp);
    MEM_AXI_ARREADY = 1;
    #1;
    check_val({tag, "_gnt0"}, GRANT, 2'b00);
    step;
    check_val({tag, "_gnt1"}, GRANT, g);
    check_val({tag, "_arvalid"}, MEM_AXI_ARVALID, 1'b1);
    check_val({tag, "_araddr"}, MEM_AXI_ARADDR, addr);
    check_val({tag, "_arready"}, {IMEM_AXI_ARREADY, DMEM_AXI_ARREADY},
              (g == 2'b01) ? 2'b10 : 2'b01);
    step;
    MEM_AXI_ARREADY = 0;
    MEM_AXI_RVALID = 1; MEM_AXI_RDATA = data; MEM_AXI_RRESP = resp;
    IMEM_AXI_RREADY = 1; DMEM_AXI_RREADY = 1;
    #1;
    check_val({tag, "_gnt2"}, GRANT, g);
    check_val({tag, "_rready"}, MEM_AXI_RREADY, 1'b1);
    if (g == 2'b01) begin
      check_val({tag, "_rdata"}, IMEM_AXI_RDATA, data);
      check_val({tag, "_rresp"}, IMEM_AXI_RRESP, resp);
      check_val({tag, "_rvalid"}, {IMEM_AXI_RVALID, DMEM_AXI_RVALID}, 2'b10);
    end else begin
      check_val({tag, "_rdata"}, DMEM_AXI_RDATA, data);
      check_val({tag, "_rresp"}, DMEM_AXI_RRESP, resp);
      check_val({tag, "_rvalid"}, {IMEM_AXI_RVALID, DMEM_AXI_RVALID}, 2'b01);
    end
    step;
    MEM_AXI_RVALID = 0; MEM_AXI_RDATA = '0; MEM_AXI_RRESP = '0;
    IMEM_AXI_RREADY = 0; DMEM_AXI_RREADY = 0;
    #1;
    check_val({tag, "_gnt3"}, GRANT, 2'b00);
    check_val({tag, "_rvalid3"}, {IMEM_AXI_RVALID, DMEM_AXI_RVALID}, 2'b00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0; n_errors = 0;
    aw_hs = 0; w_hs = 0; b_hs = 0;
`ifdef CORE_AXI_ARB_RR_EN
    first_win = 2'b01;
    post_rst_win = 2'b01;
`else
    first_win = 2'b10;
    post_rst_win = 2'b10;
`endif

    // Reset with live requests and slave responses: outputs stay quiet.
    RST = 1;
    clear_inputs();
    IMEM_AXI_ARVALID = 1; IMEM_AXI_ARADDR = 32'h1234_5678;
    DMEM_AXI_AWVALID = 1; DMEM_AXI_WDATA = 32'h0BAD_F00D; DMEM_AXI_WSTRB = 4'hF;
    MEM_AXI_RVALID = 1; MEM_AXI_RDATA = 32'hCAFE_F00D; MEM_AXI_BVALID = 1;
    step; step;
    #1;
    check_quiet("rst_init");
    clear_inputs();
    RST = 0;
    step;

    // Single IMEM read.
    IMEM_AXI_ARVALID = 1; IMEM_AXI_ARADDR = 32'h0000_0010;
    do_read("imem_rd", 2'b01, 32'h0000_0010, 32'h0000_0013, 2'b00);
    IMEM_AXI_ARVALID = 0;

    // DMEM write, W accepted two cycles ahead of AW.
    DMEM_AXI_AWVALID = 1; DMEM_AXI_AWADDR = 32'h8000_0004;
    DMEM_AXI_WVALID = 1;  DMEM_AXI_WDATA = 32'hDEAD_BEEF; DMEM_AXI_WSTRB = 4'hF;
    MEM_AXI_AWREADY = 0;  MEM_AXI_WREADY = 1;
    #1;
    check_val("wr_gnt0", GRANT, 2'b00);
    step;
    check_val("wr_gnt1", GRANT, 2'b10);
    check_val("wr_hs1", {MEM_AXI_AWVALID, MEM_AXI_WVALID, DMEM_AXI_AWREADY, DMEM_AXI_WREADY}, 4'b1101);
    check_val("wr_wdata", MEM_AXI_WDATA, 32'hDEAD_BEEF);
    check_val("wr_wstrb", MEM_AXI_WSTRB, 4'hF);
    step;
    check_val("wr_wmask", {MEM_AXI_AWVALID, MEM_AXI_WVALID, DMEM_AXI_AWREADY, DMEM_AXI_WREADY}, 4'b1000);
    step;
    MEM_AXI_AWREADY = 1;
    #1;
    check_val("wr_hs3", {MEM_AXI_AWVALID, MEM_AXI_WVALID, DMEM_AXI_AWREADY, DMEM_AXI_WREADY}, 4'b1010);
    check_val("wr_awaddr", MEM_AXI_AWADDR, 32'h8000_0004);
    step;
    DMEM_AXI_AWVALID = 0; DMEM_AXI_WVALID = 0;
    MEM_AXI_AWREADY = 0;  MEM_AXI_WREADY = 0;
    MEM_AXI_BVALID = 1;   MEM_AXI_BRESP = 2'b00; DMEM_AXI_BREADY = 1;
    #1;
    check_val("wr_b", {DMEM_AXI_BVALID, MEM_AXI_BREADY, MEM_AXI_AWVALID, MEM_AXI_WVALID}, 4'b1100);
    check_val("wr_bresp", DMEM_AXI_BRESP, 2'b00);
    check_val("wr_gnt4", GRANT, 2'b10);
    step;
    MEM_AXI_BVALID = 0; DMEM_AXI_BREADY = 0;
    #1;
    check_val("wr_gnt5", GRANT, 2'b00);
    check_val("wr_bvalid5", DMEM_AXI_BVALID, 1'b0);
    check_val("wr_aw_count", aw_hs, 1);
    check_val("wr_w_count", w_hs, 1);
    check_val("wr_b_count", b_hs, 1);
    DMEM_AXI_WDATA = '0; DMEM_AXI_WSTRB = '0; DMEM_AXI_AWADDR = '0;

    // Contention: both masters keep requesting for two transactions.
    IMEM_AXI_ARVALID = 1; IMEM_AXI_ARADDR = 32'h0000_0100;
    DMEM_AXI_ARVALID = 1; DMEM_AXI_ARADDR = 32'h0000_0200;
    do_read("cont1", first_win, (first_win == 2'b01) ? 32'h0000_0100 : 32'h0000_0200,
            32'h1111_1111, 2'b00);
    do_read("cont2", 2'b10, 32'h0000_0200, 32'h2222_2222, 2'b00);
    DMEM_AXI_ARVALID = 0;
    do_read("cont3", 2'b01, 32'h0000_0100, 32'h3333_3333, 2'b00);
    IMEM_AXI_ARVALID = 0;

    // SLVERR on a DMEM read passes through untouched.
    DMEM_AXI_ARVALID = 1; DMEM_AXI_ARADDR = 32'hFFFF_FFF0;
    do_read("slverr", 2'b10, 32'hFFFF_FFF0, 32'hBAD0_BAD0, 2'b10);
    DMEM_AXI_ARVALID = 0;

    // Slave stalls ARREADY on an IMEM read while DMEM waits.
    IMEM_AXI_ARVALID = 1; IMEM_AXI_ARADDR = 32'h0000_0040;
    MEM_AXI_ARREADY = 0;
    #1;
    check_val("stall_gnt0", GRANT, 2'b00);
    step;
    DMEM_AXI_ARVALID = 1; DMEM_AXI_ARADDR = 32'h0000_0080;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_val($sformatf("stall_gnt_c%0d", i + 1), GRANT, 2'b01);
      check_val($sformatf("stall_addr_c%0d", i + 1), MEM_AXI_ARADDR, 32'h0000_0040);
      check_val($sformatf("stall_dready_c%0d", i + 1), DMEM_AXI_ARREADY, 1'b0);
      step;
    end
    MEM_AXI_ARREADY = 1;
    #1;
    check_val("stall_iready", IMEM_AXI_ARREADY, 1'b1);
    step;
    MEM_AXI_ARREADY = 0; IMEM_AXI_ARVALID = 0;
    #1;
    check_val("stall_rd_gnt", GRANT, 2'b01);
    check_val("stall_rd_arvalid", MEM_AXI_ARVALID, 1'b0);
    step;
    MEM_AXI_RVALID = 1; MEM_AXI_RDATA = 32'h0000_0077; IMEM_AXI_RREADY = 1;
    #1;
    check_val("stall_rvalid", IMEM_AXI_RVALID, 1'b1);
    check_val("stall_rdata", IMEM_AXI_RDATA, 32'h0000_0077);
    check_val("stall_r_gnt", GRANT, 2'b01);
    step;
    MEM_AXI_RVALID = 0; MEM_AXI_RDATA = '0; IMEM_AXI_RREADY = 0;
    do_read("stall_dmem", 2'b10, 32'h0000_0080, 32'h0000_0088, 2'b00);
    DMEM_AXI_ARVALID = 0;

    // Reset while an R response is pending.
    IMEM_AXI_ARVALID = 1; IMEM_AXI_ARADDR = 32'h0000_0044;
    MEM_AXI_ARREADY = 1;
    step;
    step;
    IMEM_AXI_ARVALID = 0; MEM_AXI_ARREADY = 0;
    MEM_AXI_RVALID = 1; MEM_AXI_RDATA = 32'h5555_5555; IMEM_AXI_RREADY = 0;
    #1;
    check_val("rstmid_pending", IMEM_AXI_RVALID, 1'b1);
    check_val("rstmid_gnt", GRANT, 2'b01);
    RST = 1;
    step;
    check_quiet("rst_mid");
    RST = 0;
    MEM_AXI_RVALID = 0; MEM_AXI_RDATA = '0;
    step;

    // First contention after reset.
    IMEM_AXI_ARVALID = 1; IMEM_AXI_ARADDR = 32'h0000_0300;
    DMEM_AXI_ARVALID = 1; DMEM_AXI_ARADDR = 32'h0000_0400;
    do_read("post_rst", post_rst_win, (post_rst_win == 2'b01) ? 32'h0000_0300 : 32'h0000_0400,
            32'h4444_4444, 2'b00);
    IMEM_AXI_ARVALID = 0; DMEM_AXI_ARVALID = 0;
    step;
    check_quiet("end_idle");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
